rob_alloc_commit: RTL and testbench
===================================

Name: rob_alloc_commit

Overview:
- Reorder buffer: the receiving end of the issue-stage allocation handshake, plus writeback capture and in-order commit to the register file.
- Issue raises alloc_enable. The block returns full and next_tag, which is the tag given to the instruction's destination rename.
- Execution units (ALU/RS path and LSB path) write results back by tag.
- Completed entries retire strictly in order, one per cycle, and drive the regfile commit port.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- TAG_W, 4, tag width; equals log2(ROB_SIZE).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  global ready; low freezes all state
- alloc_enable  in  1  allocation request from issue
- alloc_rd  in  5  destination register of the issuing instruction
- alloc_optype  in  6  opcode class, stored for debug/commit
- full  out  1  no free entry
- next_tag  out  TAG_W  tag the next allocation will receive (equals tail)
- alu_wb_valid  in  1  ALU writeback strobe
- alu_wb_tag  in  TAG_W  ALU writeback tag
- alu_wb_value  in  32  ALU writeback result
- lsb_wb_valid  in  1  LSB writeback strobe
- lsb_wb_tag  in  TAG_W  LSB writeback tag
- lsb_wb_value  in  32  LSB writeback result
- query_tag  in  TAG_W  operand lookup tag
- query_ready  out  1  value for query_tag is available
- query_value  out  32  value for query_tag
- flush  in  1  discard all entries
- commit_valid  out  1  one-cycle retire pulse
- commit_tag  out  TAG_W  tag of the retired entry
- commit_rd  out  5  destination register of the retired entry
- commit_value  out  32  result of the retired entry

Behaviour:
- Storage: circular buffer with head, tail and count, where count ranges 0..ROB_SIZE. Per entry: busy, ready, rd, optype, value.
- Reset (rst=0, async): head=tail=count=0, all busy/ready=0, commit_valid=0, commit_tag=0, commit_rd=0, commit_value=0.
- full = (count==ROB_SIZE). It is combinational from registered state only; there is no same-cycle commit bypass. When full, an allocation is refused even if a commit happens in that cycle.
- next_tag = tail, always driven.
- Allocation: occurs at an edge when alloc_enable && !full && rdy && !flush. It writes entry[tail] with busy=1, ready=0, rd, optype, and does tail=tail+1 mod ROB_SIZE. A request made while full is dropped silently; issue is responsible for holding it.
- Writeback: each port applies at an edge if valid && busy[tag] && rdy, setting value and ready=1.
  - Writes to non-busy tags are ignored.
  - Both ports may write different tags in the same cycle.
  - Both ports writing the same tag is illegal; in that case the LSB value wins.
  - A writeback to an entry allocated in the same edge is ignored.
- Commit: occurs at an edge when busy[head] && ready[head] && rdy && !flush.
  - Registers commit_valid=1 and commit_tag/rd/value from entry[head].
  - Clears busy[head] and advances head.
  - Otherwise commit_valid is registered 0.
  - At most one commit per cycle.
  - rd=0 entries still commit; the regfile ignores them.
- Latency: a writeback at edge N sets ready; the commit decision is made at edge N+1; commit_valid is high during the cycle after N+1. Minimum alloc-to-commit is 2 edges after the writeback.
- Count update: +1 on allocation, -1 on commit, unchanged when both occur in the same edge.
- Query (combinational):
  - If alu_wb_valid && alu_wb_tag==query_tag, return alu_wb_value with ready=1.
  - Else if lsb matches, return lsb_wb_value with ready=1.
  - Else return busy&&ready and the stored value.
  - A non-busy tag gives query_ready=0.
- flush (synchronous, sampled only when rdy=1): highest priority. head=tail=count=0, all busy/ready cleared, commit_valid=0 next cycle. Same-cycle allocation, writeback and commit are all discarded.
- rdy=0: no state changes except that commit_valid is registered 0. Outputs stay consistent with the held state.
- Wrap-around: head and tail wrap modulo ROB_SIZE. Tags are reused after retirement.
- Reset mid-operation: all in-flight entries are lost immediately (async).

Test Plan:
- Reset, then 16 allocations (rd=1..16 mod 32) with alloc_enable held -> next_tag steps 0..15; full=1 after the 16th; a 17th request leaves tail=0 and count=16.
- Allocate tags 0,1,2; ALU writes tag2=0x33, LSB writes tag0=0x11 in the same cycle, ALU writes tag1=0x22 later -> commits in order tag0/0x11, tag1/0x22, tag2/0x33 on consecutive cycles; nothing commits before tag0 is ready.
- Writeback tag5=0xDEAD with query_tag=5 in the same cycle -> query_ready=1, query_value=0xDEAD combinationally; query of non-busy tag 9 -> query_ready=0.
- Full ROB with head ready: assert alloc_enable -> allocation refused that edge, commit occurs, full drops, and a retry next cycle succeeds with next_tag=0 (wrap).
- Eight entries in flight, flush together with alloc+wb -> next cycle count=0, next_tag=0, full=0, commit_valid stays 0; a late wb to old tag 3 is ignored.
- rdy=0 for 3 cycles with a ready head and a pending alloc -> no commit and no allocation; commit fires on the first edge after rdy=1; rst pulse mid-sequence clears commit_valid asynchronously.

Source files
------------

// File: rtl/rob_alloc_commit.sv
// Reorder buffer: accepts allocations from issue, captures ALU/LSB writebacks
// by tag, answers operand queries, and retires completed entries in order.
module rob_alloc_commit #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_enable,
    input  logic [4:0]       alloc_rd,
    input  logic [5:0]       alloc_optype,
    output logic             full,
    output logic [TAG_W-1:0] next_tag,
    input  logic             alu_wb_valid,
    input  logic [TAG_W-1:0] alu_wb_tag,
    input  logic [31:0]      alu_wb_value,
    input  logic             lsb_wb_valid,
    input  logic [TAG_W-1:0] lsb_wb_tag,
    input  logic [31:0]      lsb_wb_value,
    input  logic [TAG_W-1:0] query_tag,
    output logic             query_ready,
    output logic [31:0]      query_value,
    input  logic             flush,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [5:0]       commit_optype
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_SIZE);

    logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [4:0]          rd_d     [ROB_SIZE];
    logic [5:0]          optype_q [ROB_SIZE];
    logic [5:0]          optype_d [ROB_SIZE];
    logic [31:0]         value_q  [ROB_SIZE];
    logic [31:0]         value_d  [ROB_SIZE];

    logic             commit_valid_q, commit_valid_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_value_q, commit_value_d;
    logic [5:0]       commit_optype_q, commit_optype_d;

    logic do_alloc, do_commit, do_flush;

    // full comes from registered count only, so a same-edge commit never frees a slot early.
    assign full     = (count_q == FULL_COUNT);
    assign next_tag = tail_q;

    assign do_flush  = flush && rdy;
    assign do_alloc  = alloc_enable && !full && rdy && !flush;
    assign do_commit = busy_q[head_q] && ready_q[head_q] && rdy && !flush;

    // Next-state: allocate at tail, apply writebacks (LSB last so it wins), retire head, flush overrides all.
    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        busy_d          = busy_q;
        ready_d         = ready_q;
        rd_d            = rd_q;
        optype_d        = optype_q;
        value_d         = value_q;
        commit_valid_d  = 1'b0;
        commit_tag_d    = commit_tag_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        commit_optype_d = commit_optype_q;

        if (do_alloc) begin
            busy_d[tail_q]   = 1'b1;
            ready_d[tail_q]  = 1'b0;
            rd_d[tail_q]     = alloc_rd;
            optype_d[tail_q] = alloc_optype;
            tail_d           = tail_q + TAG_W'(1);
        end

        // Writebacks test registered busy, so an entry allocated this edge is never written.
        if (alu_wb_valid && busy_q[alu_wb_tag] && rdy) begin
            value_d[alu_wb_tag] = alu_wb_value;
            ready_d[alu_wb_tag] = 1'b1;
        end
        if (lsb_wb_valid && busy_q[lsb_wb_tag] && rdy) begin
            value_d[lsb_wb_tag] = lsb_wb_value;
            ready_d[lsb_wb_tag] = 1'b1;
        end

        if (do_commit) begin
            commit_valid_d  = 1'b1;
            commit_tag_d    = head_q;
            commit_rd_d     = rd_q[head_q];
            commit_value_d  = value_q[head_q];
            commit_optype_d = optype_q[head_q];
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
        end

        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (do_flush) begin
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            busy_d         = '0;
            ready_d        = '0;
            commit_valid_d = 1'b0;
        end
    end

    // State registers; reset drops every in-flight entry immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            commit_valid_q  <= 1'b0;
            commit_tag_q    <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_optype_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]     <= '0;
                optype_q[i] <= '0;
                value_q[i]  <= '0;
            end
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            rd_q            <= rd_d;
            optype_q        <= optype_d;
            value_q         <= value_d;
            commit_valid_q  <= commit_valid_d;
            commit_tag_q    <= commit_tag_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_optype_q <= commit_optype_d;
        end
    end

    // Operand query: live writebacks bypass the array, ALU before LSB.
    always_comb begin
        query_ready = busy_q[query_tag] && ready_q[query_tag];
        query_value = value_q[query_tag];
        if (alu_wb_valid && alu_wb_tag == query_tag) begin
            query_ready = 1'b1;
            query_value = alu_wb_value;
        end else if (lsb_wb_valid && lsb_wb_tag == query_tag) begin
            query_ready = 1'b1;
            query_value = lsb_wb_value;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_tag    = commit_tag_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_optype = commit_optype_q;

endmodule

// File: tb/tb_rob_alloc_commit.sv
// Directed bench for rob_alloc_commit: allocation/full, in-order commit,
// query bypass, wrap on full, flush, rdy stall and asynchronous reset.
module tb_rob_alloc_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_enable;
    logic [4:0]  alloc_rd;
    logic [5:0]  alloc_optype;
    logic        full;
    logic [3:0]  next_tag;
    logic        alu_wb_valid;
    logic [3:0]  alu_wb_tag;
    logic [31:0] alu_wb_value;
    logic        lsb_wb_valid;
    logic [3:0]  lsb_wb_tag;
    logic [31:0] lsb_wb_value;
    logic [3:0]  query_tag;
    logic        query_ready;
    logic [31:0] query_value;
    logic        flush;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [5:0]  commit_optype;

    int checks   = 0;
    int failures = 0;

    rob_alloc_commit #(.ROB_SIZE(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_enable(alloc_enable), .alloc_rd(alloc_rd), .alloc_optype(alloc_optype),
        .full(full), .next_tag(next_tag),
        .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_value(alu_wb_value),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_tag(lsb_wb_tag), .lsb_wb_value(lsb_wb_value),
        .query_tag(query_tag), .query_ready(query_ready), .query_value(query_value),
        .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_optype(commit_optype)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_commit(input string tag, input logic [3:0] t, input logic [4:0] rd,
                              input logic [31:0] v);
        chk({tag, "_valid"}, 32'(commit_valid), 32'd1);
        chk({tag, "_tag"},   32'(commit_tag),   32'(t));
        chk({tag, "_rd"},    32'(commit_rd),    32'(rd));
        chk({tag, "_value"}, commit_value,      v);
    endtask

    initial begin
        // Reset state
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        alloc_enable = 1'b0; alloc_rd = '0; alloc_optype = '0;
        alu_wb_valid = 1'b0; alu_wb_tag = '0; alu_wb_value = '0;
        lsb_wb_valid = 1'b0; lsb_wb_tag = '0; lsb_wb_value = '0;
        query_tag = '0;
        tick(); tick();
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_next_tag", 32'(next_tag),     32'd0);
        chk("rst_cvalid",   32'(commit_valid), 32'd0);
        chk("rst_ctag",     32'(commit_tag),   32'd0);
        chk("rst_crd",      32'(commit_rd),    32'd0);
        chk("rst_cvalue",   commit_value,      32'd0);
        rst = 1'b1;
        tick();

        // Fill all 16 entries, rd = 1..16
        alloc_enable = 1'b1;
        alloc_optype = 6'h2a;
        for (int i = 0; i < 16; i++) begin
            alloc_rd = 5'((i + 1) % 32);
            chk("fill_next_tag", 32'(next_tag), 32'(i));
            chk("fill_not_full", 32'(full),     32'd0);
            tick();
        end
        chk("filled_full",     32'(full),     32'd1);
        chk("filled_next_tag", 32'(next_tag), 32'd0);
        alloc_rd = 5'd17;
        tick();
        chk("drop17_next_tag", 32'(next_tag), 32'd0);
        chk("drop17_full",     32'(full),     32'd1);

        // Full with head becoming ready; alloc request held throughout
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd0; alu_wb_value = 32'ha0;
        tick();
        alu_wb_valid = 1'b0;
        chk("wrap_no_early_commit", 32'(commit_valid), 32'd0);
        chk("wrap_still_full",      32'(full),         32'd1);
        tick();
        chk_commit("wrap_commit0", 4'd0, 5'd1, 32'ha0);
        chk("wrap_optype",         32'(commit_optype), 32'h2a);
        chk("wrap_refused_tag",    32'(next_tag),      32'd0);
        chk("wrap_full_drops",     32'(full),          32'd0);
        tick();
        chk("wrap_retry_tag",  32'(next_tag),     32'd1);
        chk("wrap_refull",     32'(full),         32'd1);
        chk("wrap_no_commit",  32'(commit_valid), 32'd0);
        alloc_enable = 1'b0;

        // Flush a full ROB, then rebuild eight entries and flush with alloc+wb
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_full", 32'(full),     32'd0);
        chk("flush1_tag",  32'(next_tag), 32'd0);
        alloc_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alloc_rd = 5'(20 + i);
            tick();
        end
        chk("eight_next_tag", 32'(next_tag), 32'd8);
        flush = 1'b1;
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd1; alu_wb_value = 32'h99;
        tick();
        flush = 1'b0; alloc_enable = 1'b0; alu_wb_valid = 1'b0;
        chk("flush2_next_tag", 32'(next_tag),     32'd0);
        chk("flush2_full",     32'(full),         32'd0);
        chk("flush2_cvalid",   32'(commit_valid), 32'd0);
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd3; alu_wb_value = 32'h77;
        tick();
        alu_wb_valid = 1'b0;
        query_tag = 4'd3;
        #1;
        chk("late_wb_query", 32'(query_ready), 32'd0);
        tick();
        chk("late_wb_no_commit", 32'(commit_valid), 32'd0);

        // In-order commit: allocate 0,1,2 with rd 5,6,7
        alloc_enable = 1'b1;
        alloc_rd = 5'd5; tick();
        alloc_rd = 5'd6; tick();
        alloc_rd = 5'd7; tick();
        alloc_enable = 1'b0;
        tick();
        chk("order_idle", 32'(commit_valid), 32'd0);
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd2; alu_wb_value = 32'h33;
        lsb_wb_valid = 1'b1; lsb_wb_tag = 4'd0; lsb_wb_value = 32'h11;
        tick();
        lsb_wb_valid = 1'b0;
        chk("order_none_yet", 32'(commit_valid), 32'd0);
        alu_wb_tag = 4'd1; alu_wb_value = 32'h22;
        tick();
        alu_wb_valid = 1'b0;
        chk_commit("order_c0", 4'd0, 5'd5, 32'h11);
        tick();
        chk_commit("order_c1", 4'd1, 5'd6, 32'h22);
        tick();
        chk_commit("order_c2", 4'd2, 5'd7, 32'h33);
        tick();
        chk("order_done", 32'(commit_valid), 32'd0);

        // Query: allocate 3,4,5 (rd 8,9,10), writeback tag 5 with bypass
        alloc_enable = 1'b1;
        alloc_rd = 5'd8;  tick();
        alloc_rd = 5'd9;  tick();
        alloc_rd = 5'd10; tick();
        alloc_enable = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd5; alu_wb_value = 32'hdead;
        query_tag = 4'd5;
        #1;
        chk("q_bypass_ready", 32'(query_ready), 32'd1);
        chk("q_bypass_value", query_value,      32'hdead);
        query_tag = 4'd9;
        #1;
        chk("q_nonbusy", 32'(query_ready), 32'd0);
        tick();
        alu_wb_valid = 1'b0;
        query_tag = 4'd5;
        #1;
        chk("q_stored_ready", 32'(query_ready), 32'd1);
        chk("q_stored_value", query_value,      32'hdead);
        query_tag = 4'd4;
        #1;
        chk("q_busy_not_ready", 32'(query_ready), 32'd0);

        // rdy stall: make head (tag 3) and tag 4 ready, then freeze
        lsb_wb_valid = 1'b1; lsb_wb_tag = 4'd3; lsb_wb_value = 32'h44;
        alu_wb_valid = 1'b1; alu_wb_tag = 4'd4; alu_wb_value = 32'h55;
        tick();
        lsb_wb_valid = 1'b0; alu_wb_valid = 1'b0;
        rdy = 1'b0;
        alloc_enable = 1'b1; alloc_rd = 5'd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_commit", 32'(commit_valid), 32'd0);
            chk("stall_no_alloc",  32'(next_tag),     32'd6);
        end
        rdy = 1'b1;
        tick();
        alloc_enable = 1'b0;
        chk_commit("stall_release", 4'd3, 5'd8, 32'h44);
        chk("stall_alloc_tag", 32'(next_tag), 32'd7);
        tick();
        chk_commit("pre_rst_c4", 4'd4, 5'd9, 32'h55);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cvalid",   32'(commit_valid), 32'd0);
        chk("arst_next_tag", 32'(next_tag),     32'd0);
        chk("arst_cvalue",   commit_value,      32'd0);
        query_tag = 4'd5;
        #1;
        chk("arst_query_lost", 32'(query_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_cvalid", 32'(commit_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
